// File: rtl/inst_fetch_queue_pkg.sv
// Fetch queue shared types and defaults.
// State encoding for the fetch controller.
package inst_fetch_queue_pkg;

  localparam int unsigned FQ_WORD_SIZE  = 32;
  localparam int unsigned FQ_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    FQ_IDLE = 2'd0,
    FQ_WAIT = 2'd1,
    FQ_DROP = 2'd2
  } fq_state_e;

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// Instruction buffer: DEPTH entries of {pc, inst}.
// Clear wins over push/pop; head is a read mux.
module fetch_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = FQ_ADDR_WIDTH + FQ_WORD_SIZE,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_i) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front-end: one outstanding request,
// redirect/flush, FIFO to decode, miss counter.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = FQ_WORD_SIZE,
  parameter int unsigned ADDR_WIDTH = FQ_ADDR_WIDTH,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned PC_STEP    = 1,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_enable,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [WORD_SIZE-1:0]  out_inst,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_valid,
  input  logic [WORD_SIZE-1:0]  mem_data,
  input  logic                  mem_hit,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  miss_cnt
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fq_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  miss_q, miss_d;
  logic [CW-1:0]         count;
  logic [CW:0]           count_after;
  logic                  push, pop, space, issue;

  assign out_valid   = (count != '0);
  assign pop         = out_valid && out_ready && !redirect;
  assign push        = (state_q == FQ_WAIT) && mem_valid && !redirect;
  assign count_after = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
  assign space       = count_after < (CW+1)'(DEPTH);

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_WIDTH + WORD_SIZE)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (redirect),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  ({addr_q, mem_data}),
    .data_o  ({out_pc, out_inst}),
    .count_o (count)
  );

  // Controller next state, issue decision and PC update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    issue   = 1'b0;
    unique case (state_q)
      FQ_IDLE: begin
        if (redirect) pc_d = redirect_pc;
        else if (fetch_enable && count < CW'(DEPTH)) issue = 1'b1;
      end
      FQ_WAIT: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = mem_valid ? FQ_IDLE : FQ_DROP;
        end else if (mem_valid) begin
          if (fetch_enable && space) issue = 1'b1;
          else state_d = FQ_IDLE;
        end
      end
      FQ_DROP: begin
        if (redirect) pc_d = redirect_pc;
        if (mem_valid) state_d = FQ_IDLE;
      end
      default: state_d = FQ_IDLE;
    endcase
    if (issue) begin
      state_d = FQ_WAIT;
      addr_d  = pc_q;
      pc_d    = pc_q + ADDR_WIDTH'(PC_STEP);
    end
  end

  // Saturating count of responses that missed.
  always_comb begin
    miss_d = miss_q;
    if (state_q != FQ_IDLE && mem_valid && !mem_hit && miss_q != '1)
      miss_d = miss_q + CNT_WIDTH'(1);
  end

  // Controller and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FQ_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      miss_q  <= miss_d;
    end
  end

  assign mem_req  = (state_q != FQ_IDLE);
  assign busy     = (state_q != FQ_IDLE);
  assign mem_addr = addr_q;
  assign miss_cnt = miss_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomised bench for inst_fetch_queue with a
// queue-based reference model.
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_enable = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_data = '0;
  logic        mem_hit = 1'b0;
  logic        busy;
  logic [CW-1:0] miss_cnt;

  inst_fetch_queue #(
    .WORD_SIZE  (32),
    .ADDR_WIDTH (32),
    .DEPTH      (DEPTH),
    .PC_STEP    (1),
    .RESET_PC   (32'h0),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_enable (fetch_enable),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .out_inst     (out_inst),
    .out_pc       (out_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_valid    (mem_valid),
    .mem_data     (mem_data),
    .mem_hit      (mem_hit),
    .busy         (busy),
    .miss_cnt     (miss_cnt)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference model: outstanding request flag, whether its
  // response is wanted, and a queue of {pc, inst}.
  logic [31:0] m_pc, m_addr;
  bit          m_out, m_keep;
  logic [63:0] m_q [$];
  int          m_miss;

  int p_ready, p_fe, p_valid, p_idle_valid, p_redir, p_hit;
  bit data_is_addr;

  function automatic bit pct(int p);
    return $urandom_range(0, 99) < p;
  endfunction

  task automatic m_reset();
    m_pc   = 32'h0;
    m_addr = 32'h0;
    m_out  = 0;
    m_keep = 0;
    m_q.delete();
    m_miss = 0;
  endtask

  task automatic check_outputs();
    chk("out_valid", out_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("out_pc", out_pc, m_q[0][63:32]);
      chk("out_inst", out_inst, m_q[0][31:0]);
    end
    chk("mem_req", mem_req, m_out);
    if (m_out) chk("mem_addr", mem_addr, m_addr);
    chk("busy", busy, m_out);
    chk("miss_cnt", miss_cnt, m_miss);
  endtask

  task automatic drive_update();
    int  sz0;
    bit  pop, push;
    logic [31:0] rpc;
    out_ready    = pct(p_ready);
    fetch_enable = pct(p_fe);
    redirect     = pct(p_redir);
    case ($urandom_range(0, 3))
      0:       rpc = 32'h40;
      1:       rpc = 32'hFFFF_FFFE;
      2:       rpc = 32'hFFFF_FFFF;
      default: rpc = $urandom;
    endcase
    redirect_pc = rpc;
    mem_valid   = m_out ? pct(p_valid) : pct(p_idle_valid);
    mem_data    = data_is_addr ? m_addr + 32'd100 : $urandom;
    mem_hit     = pct(p_hit);

    sz0  = m_q.size();
    pop  = sz0 > 0 && out_ready && !redirect;
    push = m_out && m_keep && mem_valid && !redirect;
    if (m_out && mem_valid && !mem_hit && m_miss < (1 << CW) - 1)
      m_miss++;
    if (redirect) begin
      m_q.delete();
      m_pc = redirect_pc;
      if (m_out) begin
        if (mem_valid) m_out = 0;
        else m_keep = 0;
      end
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back({m_addr, mem_data});
      if (m_out) begin
        if (mem_valid) begin
          if (m_keep && fetch_enable && m_q.size() < DEPTH) begin
            m_addr = m_pc;
            m_pc   = m_pc + 32'd1;
          end else begin
            m_out = 0;
          end
        end
      end else if (fetch_enable && sz0 < DEPTH) begin
        m_out  = 1;
        m_keep = 1;
        m_addr = m_pc;
        m_pc   = m_pc + 32'd1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    drive_update();
  endtask

  task automatic knobs(int r, int f, int v, int iv, int rd, int h);
    p_ready = r; p_fe = f; p_valid = v;
    p_idle_valid = iv; p_redir = rd; p_hit = h;
  endtask

  initial begin
    m_reset();
    knobs(0, 0, 0, 0, 0, 100);
    data_is_addr = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_miss", miss_cnt, 0);

    // Zero-wait streaming.
    knobs(100, 100, 100, 0, 0, 100);
    drive_update();
    repeat (40) step();
    // Decode stalled: queue fills and fetch stops.
    knobs(0, 100, 100, 0, 0, 100);
    repeat (12) step();
    chk("full_valid", out_valid, 1);
    chk("full_req", mem_req, 0);
    // Drain and resume.
    knobs(100, 100, 100, 0, 0, 100);
    repeat (12) step();
    // Slow misses.
    knobs(100, 100, 20, 0, 0, 0);
    repeat (30) step();
    // Fully random traffic with redirects.
    data_is_addr = 0;
    knobs(60, 80, 35, 3, 6, 50);
    repeat (3000) step();
    // Redirect to force a known request, then async reset mid-wait.
    knobs(100, 100, 0, 0, 100, 100);
    step();
    knobs(100, 100, 0, 0, 0, 100);
    repeat (3) step();
    @(negedge clk);
    check_outputs();
    chk("pre_rst_req", mem_req, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", mem_req, 0);
    chk("arst_busy", busy, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_miss", miss_cnt, 0);
    chk("arst_addr", mem_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    data_is_addr = 1;
    knobs(100, 100, 100, 0, 0, 100);
    drive_update();
    repeat (20) step();
    @(negedge clk);
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
